// File: rtl/usbh_joypad_pkg.sv
// Shared constants and helpers for the USB-host joypad port.
// Holds the NES button bit layout, the read-counter limits and the watchdog terminal count.
package usbh_joypad_pkg;

  localparam int BTN_A     = 0;
  localparam int BTN_B     = 1;
  localparam int BTN_SEL   = 2;
  localparam int BTN_START = 3;
  localparam int BTN_U     = 4;
  localparam int BTN_D     = 5;
  localparam int BTN_L     = 6;
  localparam int BTN_R     = 7;

  localparam int BTN_W    = 8;
  localparam int RD_CNT_W = 4;
  localparam logic [RD_CNT_W-1:0] RD_CNT_MAX = 4'd8;

  // Clock cycles without a report before a player counts as stale.
  function automatic int wdog_terminal(input int clk_hz, input int timeout_ms);
    return (clk_hz / 1000) * timeout_ms;
  endfunction

  function automatic int wdog_width(input int clk_hz, input int timeout_ms);
    return $clog2(wdog_terminal(clk_hz, timeout_ms) + 1);
  endfunction

endpackage

// File: rtl/usbh_joypad_if.sv
// CPU-side controller-port bus: $4016 strobe level, per-port read pulses and serial data bits.
// The CPU bus glue is the master; the joypad port is the slave.
interface usbh_joypad_if;

  logic i_strobe;
  logic i_rd0;
  logic i_rd1;
  logic o_bit0;
  logic o_bit1;

  modport master (
    output i_strobe,
    output i_rd0,
    output i_rd1,
    input  o_bit0,
    input  o_bit1
  );

  modport slave (
    input  i_strobe,
    input  i_rd0,
    input  i_rd1,
    output o_bit0,
    output o_bit1
  );

endinterface

// File: rtl/usbh_joypad_channel.sv
// One NES controller channel: report watchdog, optional SOCD clean, strobe load and serial shift-out.
// Optional feature: define USBH_JOYPAD_SOCD_EN to cancel opposing directions before loading.
module usbh_joypad_channel
  import usbh_joypad_pkg::*;
#(
  parameter int c_clk_hz     = 48000000,
  parameter int c_timeout_ms = 100
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [BTN_W-1:0] i_btn,
  input  logic             i_valid,
  input  logic             i_strobe,
  input  logic             i_rd,
  output logic             o_bit,
  output logic             o_stale
);

  localparam int WD_TERM = wdog_terminal(c_clk_hz, c_timeout_ms);
  localparam int WD_W    = wdog_width(c_clk_hz, c_timeout_ms);
  localparam logic [WD_W-1:0] WD_TERM_V = WD_W'(WD_TERM);

  function automatic logic [BTN_W-1:0] socd_clean(input logic [BTN_W-1:0] w);
    logic [BTN_W-1:0] c;
    c = w;
`ifdef USBH_JOYPAD_SOCD_EN
    // The decoder's reset combo forces all four directions; it must reach the CPU intact.
    if (!(w[BTN_A] && w[BTN_B] && w[BTN_SEL] && w[BTN_START])) begin
      if (w[BTN_L] && w[BTN_R]) begin
        c[BTN_L] = 1'b0;
        c[BTN_R] = 1'b0;
      end
      if (w[BTN_U] && w[BTN_D]) begin
        c[BTN_U] = 1'b0;
        c[BTN_D] = 1'b0;
      end
    end
`endif
    return c;
  endfunction

  function automatic logic [RD_CNT_W-1:0] rd_cnt_inc(input logic [RD_CNT_W-1:0] c);
    return (c == RD_CNT_MAX) ? c : c + 1'b1;
  endfunction

  function automatic logic [WD_W-1:0] wd_cnt_inc(input logic [WD_W-1:0] c);
    return (c == WD_TERM_V) ? c : c + 1'b1;
  endfunction

  logic [WD_W-1:0]     wd_cnt_p0;
  logic                stale;
  logic [BTN_W-1:0]    eff_word;
  logic [BTN_W-1:0]    shift_p0;
  logic [RD_CNT_W-1:0] rd_cnt_p0;
  logic [RD_CNT_W-1:0] rd_cnt_nxt;
  logic                bit_p0;

  // Watchdog: reset and silence both sit at terminal, so a player starts out stale.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wd_cnt_p0 <= WD_TERM_V;
    end else if (i_valid) begin
      wd_cnt_p0 <= '0;
    end else begin
      wd_cnt_p0 <= wd_cnt_inc(wd_cnt_p0);
    end
  end

  assign stale      = (wd_cnt_p0 == WD_TERM_V);
  assign eff_word   = stale ? '0 : socd_clean(i_btn);
  assign rd_cnt_nxt = rd_cnt_inc(rd_cnt_p0);

  // Strobe level reloads every cycle and masks reads; a read shifts in ones behind the data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift_p0  <= '0;
      rd_cnt_p0 <= '0;
      bit_p0    <= 1'b0;
    end else if (i_strobe) begin
      shift_p0  <= eff_word;
      rd_cnt_p0 <= '0;
      bit_p0    <= eff_word[0];
    end else if (i_rd) begin
      shift_p0  <= {1'b1, shift_p0[BTN_W-1:1]};
      rd_cnt_p0 <= rd_cnt_nxt;
      bit_p0    <= (rd_cnt_nxt == RD_CNT_MAX) ? 1'b1 : shift_p0[1];
    end
  end

  assign o_bit   = bit_p0;
  assign o_stale = stale;

endmodule

// File: rtl/usbh_joypad_port.sv
// Two-player NES controller-port front end between the USB report decoders and the CPU bus glue.
// Optional feature macro: USBH_JOYPAD_SOCD_EN (opposing-direction clean, applied inside each channel).
module usbh_joypad_port
  import usbh_joypad_pkg::*;
#(
  parameter int c_clk_hz     = 48000000,
  parameter int c_timeout_ms = 100
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [BTN_W-1:0]   i_btn0,
  input  logic [BTN_W-1:0]   i_btn1,
  input  logic               i_valid0,
  input  logic               i_valid1,
  usbh_joypad_if.slave       cpu,
  output logic [1:0]         o_stale
);

  logic stale0;
  logic stale1;

  usbh_joypad_channel #(
    .c_clk_hz     (c_clk_hz),
    .c_timeout_ms (c_timeout_ms)
  ) u_ch0 (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_btn    (i_btn0),
    .i_valid  (i_valid0),
    .i_strobe (cpu.i_strobe),
    .i_rd     (cpu.i_rd0),
    .o_bit    (cpu.o_bit0),
    .o_stale  (stale0)
  );

  usbh_joypad_channel #(
    .c_clk_hz     (c_clk_hz),
    .c_timeout_ms (c_timeout_ms)
  ) u_ch1 (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_btn    (i_btn1),
    .i_valid  (i_valid1),
    .i_strobe (cpu.i_strobe),
    .i_rd     (cpu.i_rd1),
    .o_bit    (cpu.o_bit1),
    .o_stale  (stale1)
  );

  assign o_stale = {stale1, stale0};

endmodule

// File: tb/tb_usbh_joypad_port.sv
// Bench for usbh_joypad_port: directed protocol scenarios plus randomized traffic against a read-queue model.
// Expectations follow USBH_JOYPAD_SOCD_EN when it is defined for the build.
module tb_usbh_joypad_port;

  localparam int CLK_HZ = 20000;
  localparam int TO_MS  = 3;
  localparam int T      = 60;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] btn0 = 8'h00;
  logic [7:0] btn1 = 8'h00;
  logic       valid0 = 1'b0;
  logic       valid1 = 1'b0;
  logic [1:0] stale;

  usbh_joypad_if cpu ();

  usbh_joypad_port #(
    .c_clk_hz     (CLK_HZ),
    .c_timeout_ms (TO_MS)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_btn0   (btn0),
    .i_btn1   (btn1),
    .i_valid0 (valid0),
    .i_valid1 (valid1),
    .cpu      (cpu.slave),
    .o_stale  (stale)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: the word latched at the last load, how many reads have consumed it, cycles since last report.
  logic [7:0] m_word [2];
  int         m_reads[2];
  int         m_age  [2];

  function automatic logic [7:0] ref_clean(input logic [7:0] w);
    logic [7:0] r;
    r = w;
`ifdef USBH_JOYPAD_SOCD_EN
    if (w[3:0] != 4'hF) begin
      if (w[7:6] == 2'b11) r[7:6] = 2'b00;
      if (w[5:4] == 2'b11) r[5:4] = 2'b00;
    end
`endif
    return r;
  endfunction

  function automatic logic exp_bit(input int p);
    if (m_reads[p] >= 8) return 1'b1;
    return m_word[p][m_reads[p]];
  endfunction

  function automatic logic [1:0] exp_stale();
    return {m_age[1] == T, m_age[0] == T};
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_word[p]  = 8'h00;
      m_reads[p] = 0;
      m_age[p]   = T;
    end
  endtask

  task automatic model_edge();
    logic [7:0] b;
    logic       v;
    logic       r;
    for (int p = 0; p < 2; p++) begin
      b = (p == 0) ? btn0 : btn1;
      v = (p == 0) ? valid0 : valid1;
      r = (p == 0) ? cpu.i_rd0 : cpu.i_rd1;
      if (cpu.i_strobe) begin
        m_word[p]  = (m_age[p] == T) ? 8'h00 : ref_clean(b);
        m_reads[p] = 0;
      end else if (r && m_reads[p] < 8) begin
        m_reads[p] = m_reads[p] + 1;
      end
      if (v) m_age[p] = 0;
      else if (m_age[p] < T) m_age[p] = m_age[p] + 1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_bit0"}, {7'b0, cpu.o_bit0}, {7'b0, exp_bit(0)});
    chk({tag, "_bit1"}, {7'b0, cpu.o_bit1}, {7'b0, exp_bit(1)});
    chk({tag, "_stale"}, {6'b0, stale}, {6'b0, exp_stale()});
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    valid0    = 1'b0;
    valid1    = 1'b0;
    cpu.i_rd0 = 1'b0;
    cpu.i_rd1 = 1'b0;
    check_all(tag);
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish within time bound");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] t2_bits;
    logic [7:0] w;
    logic [7:0] socd_exp;

    cpu.i_strobe = 1'b0;
    cpu.i_rd0    = 1'b0;
    cpu.i_rd1    = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    chk("reset_stale_const", {6'b0, stale}, 8'h03);
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh reset, no reports: loads blank word, eight zeros then ones.
    cpu.i_strobe = 1'b1;
    step("t1_load");
    cpu.i_strobe = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk("t1_bit0", {7'b0, cpu.o_bit0}, (i < 8) ? 8'h00 : 8'h01);
      cpu.i_rd0 = 1'b1;
      step("t1_rd");
    end
    chk("t1_stale", {6'b0, stale}, 8'h03);

    // Word 8'h09: A and Start pressed.
    btn0 = 8'h09;
    valid0 = 1'b1;
    step("t2_kick");
    cpu.i_strobe = 1'b1;
    step("t2_load");
    cpu.i_strobe = 1'b0;
    t2_bits = 10'b11_0000_1001;
    for (int i = 0; i < 10; i++) begin
      chk("t2_bit0", {7'b0, cpu.o_bit0}, {7'b0, t2_bits[i]});
      cpu.i_rd0 = 1'b1;
      step("t2_rd");
    end

    // Strobe held high: o_bit1 tracks A, reads ignored.
    valid1 = 1'b1;
    step("t3_kick");
    cpu.i_strobe = 1'b1;
    for (int i = 0; i < 6; i++) begin
      btn1 = (i % 2 == 0) ? 8'h01 : 8'h00;
      cpu.i_rd1 = 1'b1;
      step("t3_hold");
      chk("t3_bit1", {7'b0, cpu.o_bit1}, {7'b0, btn1[0]});
    end
    cpu.i_strobe = 1'b0;

    // Read and strobe in the same cycle after three reads: reload wins.
    btn0 = 8'h06;
    valid0 = 1'b1;
    step("t4_kick");
    cpu.i_strobe = 1'b1;
    step("t4_load");
    cpu.i_strobe = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu.i_rd0 = 1'b1;
      step("t4_rd");
    end
    btn0 = 8'h05;
    cpu.i_strobe = 1'b1;
    cpu.i_rd0 = 1'b1;
    step("t4_coll");
    chk("t4_newbit", {7'b0, cpu.o_bit0}, 8'h01);
    cpu.i_strobe = 1'b0;
    w = 8'h05;
    for (int i = 0; i < 9; i++) begin
      chk("t4_bit0", {7'b0, cpu.o_bit0}, (i < 8) ? {7'b0, w[i]} : 8'h01);
      cpu.i_rd0 = 1'b1;
      step("t4_rd2");
    end

    // Watchdog expiry at exactly T cycles after the last report.
    valid1 = 1'b1;
    valid0 = 1'b1;
    step("t5_kick");
    for (int k = 1; k <= T; k++) begin
      if (k % 20 == 0) valid1 = 1'b1;
      step("t5_wait");
      if (k == T - 1) chk("t5_not_yet", {7'b0, stale[0]}, 8'h00);
      if (k == T)     chk("t5_expired", {7'b0, stale[0]}, 8'h01);
    end
    btn0 = 8'h0F;
    cpu.i_strobe = 1'b1;
    step("t5_load");
    cpu.i_strobe = 1'b0;
    chk("t5_blank", {7'b0, cpu.o_bit0}, 8'h00);

    // Stale arrives mid-shift: loaded data still shifts out.
    btn0 = 8'h03;
    valid0 = 1'b1;
    step("t6_kick");
    for (int k = 1; k <= T - 2; k++) step("t6_wait");
    cpu.i_strobe = 1'b1;
    step("t6_load");
    cpu.i_strobe = 1'b0;
    step("t6_idle");
    chk("t6_stale", {7'b0, stale[0]}, 8'h01);
    w = 8'h03;
    for (int i = 0; i < 3; i++) begin
      chk("t6_bit0", {7'b0, cpu.o_bit0}, {7'b0, w[i]});
      cpu.i_rd0 = 1'b1;
      step("t6_rd");
    end

    // Opposing directions and the reset combo.
    for (int s = 0; s < 3; s++) begin
      w = (s == 0) ? 8'hC0 : (s == 1) ? 8'h30 : 8'hFF;
`ifdef USBH_JOYPAD_SOCD_EN
      socd_exp = (s == 2) ? 8'hFF : 8'h00;
`else
      socd_exp = w;
`endif
      btn0 = w;
      valid0 = 1'b1;
      step("t7_kick");
      cpu.i_strobe = 1'b1;
      step("t7_load");
      cpu.i_strobe = 1'b0;
      for (int i = 0; i < 8; i++) begin
        chk("t7_socd", {7'b0, cpu.o_bit0}, {7'b0, socd_exp[i]});
        cpu.i_rd0 = 1'b1;
        step("t7_rd");
      end
    end

    // Randomized traffic on both players.
    for (int n = 0; n < 3000; n++) begin
      btn0 = 8'($urandom);
      btn1 = 8'($urandom);
      valid0 = ($urandom_range(0, 99) < 2);
      valid1 = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 6) cpu.i_strobe = ~cpu.i_strobe;
      cpu.i_rd0 = ($urandom_range(0, 99) < 30);
      cpu.i_rd1 = ($urandom_range(0, 99) < 30);
      step("rnd");
    end
    cpu.i_strobe = 1'b0;

    // Asynchronous reset in the middle of a read sequence.
    btn0 = 8'hFF;
    btn1 = 8'hFF;
    valid0 = 1'b1;
    valid1 = 1'b1;
    step("t8_kick");
    cpu.i_strobe = 1'b1;
    step("t8_load");
    cpu.i_strobe = 1'b0;
    cpu.i_rd0 = 1'b1;
    step("t8_rd");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t8_rst");
    chk("t8_bits", {6'b0, cpu.o_bit1, cpu.o_bit0}, 8'h00);
    chk("t8_stale", {6'b0, stale}, 8'h03);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cpu.i_rd0 = 1'b1;
      cpu.i_rd1 = 1'b1;
      step("t8_post");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
